detect_seq_ctrl: RTL and testbench



---
 rtl/detect_seq_pkg.sv | 16 +
 rtl/run_detector.sv | 49 ++++
 rtl/detect_seq_ctrl.sv | 139 +++++++++++++
 tb/tb_detect_seq_ctrl.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/detect_seq_pkg.sv
// Shared types and default constants for the serial run-detect sequencer.
//   state_e       : sequencer FSM states (idle, shifting bits out, reporting result)
//   DefWordW      : default word width
//   DefRunLen     : default run length that counts as a hit
package detect_seq_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StShift  = 2'd1,
        StReport = 2'd2
    } state_e;

    localparam int unsigned DefWordW  = 16;
    localparam int unsigned DefRunLen = 3;

endpackage

// File: rtl/run_detector.sv
// Serial run detector: tracks the length of the current run of identical bits.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   start      : x is the first bit of a new word (history is discarded)
//   en         : x is valid this cycle; state advances only when set
//   x          : serial input bit
//   hit        : updated run length has reached RUN_LEN (combinational)
//   run_len    : registered run length (saturates at RUN_LEN)
module run_detector
    import detect_seq_pkg::*;
#(
    parameter int unsigned RUN_LEN = DefRunLen,
    localparam int unsigned RlW    = $clog2(RUN_LEN + 1)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           en,
    input  logic           x,
    output logic           hit,
    output logic [RlW-1:0] run_len
);

    logic [RlW-1:0] run_q, run_d, run_upd;
    logic           prev_q, prev_d;

    always_comb begin
        run_upd = RlW'(1);
        if (!start && (x == prev_q)) begin
            run_upd = (run_q >= RlW'(RUN_LEN)) ? run_q : RlW'(run_q + 1'b1);
        end
        hit    = en && (run_upd >= RlW'(RUN_LEN));
        run_d  = en ? run_upd : run_q;
        prev_d = en ? x : prev_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            run_q  <= '0;
            prev_q <= 1'b0;
        end else begin
            run_q  <= run_d;
            prev_q <= prev_d;
        end
    end

    assign run_len = run_q;

endmodule

// File: rtl/detect_seq_ctrl.sv
// Parallel-to-serial sequencer around run_detector. Accepts a word on the
// in_* handshake, shifts it MSB-first into the detector one bit per clock,
// counts hits and returns the count on the out_* handshake.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   in_valid/in_ready     : input word handshake, in_word is the word (MSB first)
//   ser_x, ser_hit        : bit presented to detector and its hit flag
//   busy                  : high while shifting or reporting
//   out_valid/out_ready   : result handshake, out_count is the hit count
//   out_first_idx         : index of first hit, WORD_W if none
//                           (only with DETECT_SEQ_FIRST_IDX_EN defined)
module detect_seq_ctrl
    import detect_seq_pkg::*;
#(
    parameter int unsigned WORD_W  = DefWordW,
    parameter int unsigned RUN_LEN = DefRunLen,
    parameter int unsigned CNT_W   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_word,
    output logic              ser_x,
    output logic              ser_hit,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
`ifdef DETECT_SEQ_FIRST_IDX_EN
    output logic [CNT_W-1:0]  out_first_idx,
`endif
    output logic [CNT_W-1:0]  out_count
);

    localparam int unsigned RlW = $clog2(RUN_LEN + 1);

    state_e              state_q, state_d;
    logic [WORD_W-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                shifting;
    logic                det_hit;
    logic [RlW-1:0]      det_run_len;

    assign shifting = (state_q == StShift);

    run_detector #(
        .RUN_LEN (RUN_LEN)
    ) u_run_detector (
        .clk     (clk),
        .reset   (reset),
        .start   (idx_q == '0),
        .en      (shifting),
        .x       (shreg_q[WORD_W-1]),
        .hit     (det_hit),
        .run_len (det_run_len)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            shreg_q <= '0;
            idx_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
            count_q <= count_d;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        idx_d   = idx_q;
        count_d = count_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    shreg_d = in_word;
                    idx_d   = '0;
                    count_d = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                shreg_d = {shreg_q[WORD_W-2:0], 1'b0};
                idx_d   = CNT_W'(idx_q + 1'b1);
                if (det_hit) count_d = CNT_W'(count_q + 1'b1);
                if (idx_q == CNT_W'(WORD_W - 1)) begin
                    idx_d   = '0;
                    state_d = StReport;
                end
            end
            StReport: begin
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        in_ready  = (state_q == StIdle);
        busy      = (state_q != StIdle);
        out_valid = (state_q == StReport);
        out_count = out_valid ? count_q : '0;
        ser_x     = shifting ? shreg_q[WORD_W-1] : 1'b0;
        ser_hit   = det_hit;
    end

`ifdef DETECT_SEQ_FIRST_IDX_EN
    logic [CNT_W-1:0] first_q, first_d;

    always_ff @(posedge clk) begin
        if (reset) first_q <= '0;
        else       first_q <= first_d;
    end

    // WORD_W is never a valid bit index, so it doubles as "no hit yet".
    always_comb begin
        first_d = first_q;
        if (state_q == StIdle && in_valid) begin
            first_d = CNT_W'(WORD_W);
        end else if (shifting && det_hit && first_q == CNT_W'(WORD_W)) begin
            first_d = idx_q;
        end
    end

    assign out_first_idx = out_valid ? first_q : '0;
`endif

    logic unused_run_len;
    assign unused_run_len = ^det_run_len;

endmodule

// File: tb/tb_detect_seq_ctrl.sv
module tb_detect_seq_ctrl;

    localparam int WORD_W  = 16;
    localparam int RUN_LEN = 3;
    localparam int CNT_W   = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_word;
    logic              ser_x;
    logic              ser_hit;
    logic              busy;
    logic              out_valid;
    logic              out_ready;
    logic [CNT_W-1:0]  out_count;
`ifdef DETECT_SEQ_FIRST_IDX_EN
    logic [CNT_W-1:0]  out_first_idx;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    detect_seq_ctrl #(
        .WORD_W  (WORD_W),
        .RUN_LEN (RUN_LEN),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_word   (in_word),
        .ser_x     (ser_x),
        .ser_hit   (ser_hit),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef DETECT_SEQ_FIRST_IDX_EN
        .out_first_idx (out_first_idx),
`endif
        .out_count (out_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Bit k (k=0 is MSB) is a hit when it closes a window of RUN_LEN equal bits.
    function automatic bit model_hit(input logic [WORD_W-1:0] w, input int k);
        if (k < RUN_LEN - 1) return 1'b0;
        for (int j = k - RUN_LEN + 1; j < k; j++) begin
            if (w[WORD_W-1-j] != w[WORD_W-1-k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int model_count(input logic [WORD_W-1:0] w);
        int c = 0;
        for (int k = 0; k < WORD_W; k++) c += int'(model_hit(w, k));
        return c;
    endfunction

    function automatic int model_first(input logic [WORD_W-1:0] w);
        for (int k = 0; k < WORD_W; k++) if (model_hit(w, k)) return k;
        return WORD_W;
    endfunction

    task automatic check_idle(input string tag);
        check_eq({tag, "_in_ready"}, 32'(in_ready), 1);
        check_eq({tag, "_busy"}, 32'(busy), 0);
        check_eq({tag, "_out_valid"}, 32'(out_valid), 0);
        check_eq({tag, "_ser_x"}, 32'(ser_x), 0);
        check_eq({tag, "_ser_hit"}, 32'(ser_hit), 0);
        check_eq({tag, "_out_count"}, 32'(out_count), 0);
    endtask

    // Sends one word and checks every shift cycle and the report phase.
    // bp: cycles of out_ready=0 after out_valid; abort_at < WORD_W resets mid-shift.
    task automatic send_word(input logic [WORD_W-1:0] w, input int bp, input int abort_at);
        int guard = 0;
        int cnt   = model_count(w);
        int first = model_first(w);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check_eq("accept_ready", 32'(in_ready), 1);
        in_valid = 1'b1;
        in_word  = w;
        @(negedge clk);
        for (int k = 0; k < WORD_W; k++) begin
            // Traffic outside IDLE must be ignored.
            in_valid  = 1'($urandom);
            in_word   = WORD_W'($urandom);
            out_ready = 1'($urandom);
            check_eq($sformatf("ser_x[%0d]", k), 32'(ser_x), 32'(w[WORD_W-1-k]));
            check_eq($sformatf("ser_hit[%0d]", k), 32'(ser_hit), 32'(model_hit(w, k)));
            check_eq("shift_busy", 32'(busy), 1);
            check_eq("shift_in_ready", 32'(in_ready), 0);
            check_eq("shift_out_valid", 32'(out_valid), 0);
            if (k == abort_at) begin
                reset    = 1'b1;
                in_valid = 1'b0;
                @(negedge clk);
                reset = 1'b0;
                check_idle("abort");
                return;
            end
            @(negedge clk);
        end
        for (int c = 0; c <= bp; c++) begin
            check_eq("rep_out_valid", 32'(out_valid), 1);
            check_eq("rep_count", 32'(out_count), 32'(cnt));
            check_eq("rep_in_ready", 32'(in_ready), 0);
            check_eq("rep_busy", 32'(busy), 1);
            check_eq("rep_ser_x", 32'(ser_x), 0);
`ifdef DETECT_SEQ_FIRST_IDX_EN
            check_eq("rep_first_idx", 32'(out_first_idx), 32'(first));
`endif
            in_valid  = 1'($urandom);
            out_ready = (c == bp);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check_idle("post");
        if (first < 0) n_fail++;
    endtask

    logic [WORD_W-1:0] w_t;

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_word   = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        reset = 1'b0;
        @(negedge clk);
        check_idle("after_reset");

        send_word(16'b0001111000111001, 0, WORD_W);
        send_word(16'h0000, 0, WORD_W);
        send_word(16'hAAAA, 0, WORD_W);
        send_word(16'h5555, 10, WORD_W);
        send_word(16'hFFFF, 0, WORD_W);
        send_word(16'h0F0F, 0, WORD_W);
        send_word(16'hFFFF, 0, 6);
        send_word(16'hFFFF, 0, WORD_W);
        send_word(16'h8000, 2, WORD_W);
        send_word(16'h0001, 1, WORD_W);
        for (int i = 0; i < 40; i++) begin
            w_t = WORD_W'($urandom);
            send_word(w_t, int'($urandom_range(0, 3)),
                      ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, WORD_W - 1)) : WORD_W);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
